// File: rtl/ppd_pkg.sv
// Shared types and helpers for the packet-presence detector.
package ppd_pkg;

    // Burst gating state machine.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS    = 2'd1,
        HOLDOFF = 2'd2
    } ppd_state_e;

    // |I|+|Q| needs one bit more than a component (|-2^(W-1)| is exact).
    function automatic int mag_w(input int data_w);
        return data_w + 1;
    endfunction

    // A full long window of maximum magnitudes fits without wrapping.
    function automatic int sum_w(input int data_w, input int long_log2);
        return data_w + 1 + long_log2;
    endfunction

    // Absolute value of a sign-extended component.
    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return (v < 0) ? 32'(-v) : 32'(v);
    endfunction

endpackage

// File: rtl/ppd_if.sv
// Valid-only sample stream (no backpressure).
interface ppd_if #(
    parameter int W = 48
);
    logic [W-1:0] data;
    logic         valid;

    modport master (output data, output valid);
    modport slave  (input  data, input  valid);
endinterface

// File: rtl/ppd_mag_ring.sv
// Magnitude history ring: one write port, two registered read taps at the
// long-window and short-window delays. Contents are not cleared; the owner
// masks taps that point at entries older than the last reset/clear.
module ppd_mag_ring #(
    parameter int MAG_W      = 13,
    parameter int LONG_LOG2  = 8,
    parameter int SHORT_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [LONG_LOG2-1:0] wr_ptr,
    input  logic [MAG_W-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [LONG_LOG2-1:0] rd_ptr,
    output logic [MAG_W-1:0]     long_tap,
    output logic [MAG_W-1:0]     short_tap
);
    localparam int DEPTH = 1 << LONG_LOG2;
    localparam logic [LONG_LOG2-1:0] SHORT_OFF = LONG_LOG2'(1 << SHORT_LOG2);

    logic [MAG_W-1:0]     mem [DEPTH];
    logic [LONG_LOG2-1:0] short_addr;

    assign short_addr = rd_ptr - SHORT_OFF;

    // Store the magnitude of the sample being accumulated.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Fetch both delayed magnitudes one cycle ahead of their use.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            long_tap  <= mem[rd_ptr];
            short_tap <= mem[short_addr];
        end
    end
endmodule

// File: rtl/ppd_detector_mc.sv
// Packet-presence detector: short/long |I|+|Q| moving sums on one channel,
// forwarding fixed-length bursts when short energy dominates long energy.
module ppd_detector_mc
    import ppd_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int NCH        = 2,
    parameter int LONG_LOG2  = 8,
    parameter int SHORT_LOG2 = 4,
    parameter int THR_FRAC   = 4,
    parameter int LEN_W      = 16,
    parameter int RETRIGGER  = 1,
    localparam int SUM_W     = sum_w(DATA_W, LONG_LOG2),
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    ppd_if.slave              in_if,
    ppd_if.master             out_if,
    input  logic              cfg_enable,
    input  logic [7:0]        cfg_threshold,
    input  logic [LEN_W-1:0]  cfg_passthrough_len,
    input  logic [LEN_W-1:0]  cfg_holdoff_len,
    input  logic [CH_W-1:0]   cfg_det_ch,
    input  logic              cfg_clear_rs,
    output logic [31:0]       dbg_count,
    output logic [SUM_W-1:0]  dbg_long_sum,
    output logic [SUM_W-1:0]  dbg_short_sum,
    output logic              det_active
);
    localparam int MAG_W       = mag_w(DATA_W);
    localparam int W2          = 2 * DATA_W;
    localparam int DW          = NCH * W2;
    localparam int FILL_W      = LONG_LOG2 + 1;
    localparam int CMP_W       = SUM_W + 8;
    localparam int SHIFT       = LONG_LOG2 - SHORT_LOG2;
    localparam int LONG_DEPTH  = 1 << LONG_LOG2;
    localparam int SHORT_DEPTH = 1 << SHORT_LOG2;

    logic [MAG_W-1:0]     ch_mag [NCH];
    logic [MAG_W-1:0]     sel_mag;
    logic                 accept_in, s2_go;
    logic                 s1_valid_reg;
    logic [DW-1:0]        s1_data_reg;
    logic [MAG_W-1:0]     s1_mag_reg;
    logic [LONG_LOG2-1:0] ptr_reg, rd_ptr;
    logic [FILL_W-1:0]    fill_reg;
    logic [MAG_W-1:0]     long_tap, short_tap, long_old, short_old;
    logic [SUM_W-1:0]     long_sum_reg, short_sum_reg, long_upd, short_upd;
    logic [CMP_W-1:0]     cmp_lhs, cmp_rhs;
    logic                 warm, trig;
    ppd_state_e           state_reg, state_next;
    logic [LEN_W-1:0]     rem_reg, rem_next, hold_reg, hold_next;
    logic [LEN_W-1:0]     burst_len, rem_after;
    logic                 in_burst, fwd, count_inc;
    logic [31:0]          count_reg;
    logic                 out_valid_reg;
    logic [DW-1:0]        out_data_reg;

    // Per-channel magnitude; the detection channel is picked afterwards.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_mag
        logic signed [DATA_W-1:0] i_s, q_s;
        assign i_s = in_if.data[gi*W2 + DATA_W +: DATA_W];
        assign q_s = in_if.data[gi*W2 +: DATA_W];
        assign ch_mag[gi] = MAG_W'(abs32(32'(i_s))) + MAG_W'(abs32(32'(q_s)));
    end

    assign sel_mag   = (int'(cfg_det_ch) < NCH) ? ch_mag[cfg_det_ch] : '0;
    // Clear wins over both the arriving sample and the one in flight.
    assign accept_in = in_if.valid && !cfg_clear_rs;
    assign s2_go     = s1_valid_reg && !cfg_clear_rs;
    // The sample entering S1 sees the pointer after the S2 sample advances it.
    assign rd_ptr    = ptr_reg + LONG_LOG2'(s2_go);

    // Stage 1: capture sample and its detection magnitude.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_mag_reg   <= '0;
        end else begin
            s1_valid_reg <= accept_in;
            if (accept_in) begin
                s1_data_reg <= in_if.data;
                s1_mag_reg  <= sel_mag;
            end
        end
    end

    ppd_mag_ring #(
        .MAG_W      (MAG_W),
        .LONG_LOG2  (LONG_LOG2),
        .SHORT_LOG2 (SHORT_LOG2)
    ) u_ring (
        .clk       (clk_clk),
        .wr_en     (s2_go),
        .wr_ptr    (ptr_reg),
        .wr_data   (s1_mag_reg),
        .rd_en     (accept_in),
        .rd_ptr    (rd_ptr),
        .long_tap  (long_tap),
        .short_tap (short_tap)
    );

    // Ring entries not yet written since reset/clear count as zero.
    assign long_old  = fill_reg[LONG_LOG2] ? long_tap : '0;
    assign short_old = (fill_reg >= FILL_W'(SHORT_DEPTH)) ? short_tap : '0;
    assign long_upd  = long_sum_reg + SUM_W'(s1_mag_reg) - SUM_W'(long_old);
    assign short_upd = short_sum_reg + SUM_W'(s1_mag_reg) - SUM_W'(short_old);
    // Warm once the current sample completes a full long window.
    assign warm      = fill_reg >= FILL_W'(LONG_DEPTH - 1);
    assign cmp_lhs   = CMP_W'(short_upd) << SHIFT;
    assign cmp_rhs   = (CMP_W'(long_upd) * CMP_W'(cfg_threshold)) >> THR_FRAC;
    assign trig      = warm && (cmp_lhs > cmp_rhs);
    assign burst_len = (cfg_passthrough_len == '0) ? LEN_W'(1) : cfg_passthrough_len;

    // Next-state and forwarding decision for the sample in stage 2.
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        hold_next  = hold_reg;
        rem_after  = '0;
        in_burst   = 1'b0;
        fwd        = 1'b0;
        count_inc  = 1'b0;
        if (!cfg_enable) begin
            state_next = IDLE;
            fwd        = 1'b1;
        end else if (s2_go) begin
            unique case (state_reg)
                IDLE: begin
                    if (trig) begin
                        fwd       = 1'b1;
                        count_inc = 1'b1;
                        in_burst  = 1'b1;
                        rem_after = burst_len - LEN_W'(1);
                    end
                end
                PASS: begin
                    fwd      = 1'b1;
                    in_burst = 1'b1;
                    if (RETRIGGER != 0 && trig) begin
                        count_inc = 1'b1;
                        rem_after = burst_len - LEN_W'(1);
                    end else begin
                        rem_after = rem_reg - LEN_W'(1);
                    end
                end
                HOLDOFF: begin
                    hold_next = hold_reg - LEN_W'(1);
                    if (hold_reg <= LEN_W'(1)) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
            if (in_burst) begin
                rem_next = rem_after;
                if (rem_after != '0) begin
                    state_next = PASS;
                end else if (cfg_holdoff_len != '0) begin
                    state_next = HOLDOFF;
                    hold_next  = cfg_holdoff_len;
                end else begin
                    state_next = IDLE;
                end
            end
        end
    end

    // Stage 2: sums, history pointer, FSM, trigger count and output register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            hold_reg      <= '0;
            long_sum_reg  <= '0;
            short_sum_reg <= '0;
            ptr_reg       <= '0;
            fill_reg      <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (cfg_clear_rs) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            hold_reg      <= '0;
            long_sum_reg  <= '0;
            short_sum_reg <= '0;
            ptr_reg       <= '0;
            fill_reg      <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rem_reg       <= rem_next;
            hold_reg      <= hold_next;
            out_valid_reg <= s2_go && fwd;
            if (s2_go) begin
                long_sum_reg  <= long_upd;
                short_sum_reg <= short_upd;
                ptr_reg       <= ptr_reg + LONG_LOG2'(1);
                if (!fill_reg[LONG_LOG2]) fill_reg <= fill_reg + FILL_W'(1);
                if (fwd) out_data_reg <= s1_data_reg;
            end
            if (count_inc && count_reg != '1) count_reg <= count_reg + 32'd1;
        end
    end

    assign out_if.valid  = out_valid_reg;
    assign out_if.data   = out_data_reg;
    assign dbg_count     = count_reg;
    assign dbg_long_sum  = long_sum_reg;
    assign dbg_short_sum = short_sum_reg;
    assign det_active    = (state_reg == PASS);
endmodule

// File: tb/tb_ppd_detector_mc.sv
// Randomised and directed bench for ppd_detector_mc against a window-sum model.
module tb_ppd_detector_mc;
    localparam int DATA_W   = 12;
    localparam int NCH      = 2;
    localparam int LONG_L2  = 8;
    localparam int SHORT_L2 = 4;
    localparam int THR_FRAC = 4;
    localparam int LEN_W    = 16;
    localparam int RETRIG   = 1;
    localparam int DW       = NCH * 2 * DATA_W;
    localparam int SUM_W    = DATA_W + 1 + LONG_L2;
    localparam int LONG_N   = 1 << LONG_L2;
    localparam int SHORT_N  = 1 << SHORT_L2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_enable, cfg_clear_rs;
    logic [7:0]       cfg_threshold;
    logic [LEN_W-1:0] cfg_passthrough_len, cfg_holdoff_len;
    logic [0:0]       cfg_det_ch;
    logic [31:0]      dbg_count;
    logic [SUM_W-1:0] dbg_long_sum, dbg_short_sum;
    logic             det_active;

    ppd_if #(.W(DW)) in_if ();
    ppd_if #(.W(DW)) out_if ();

    always #5 clk = ~clk;

    ppd_detector_mc #(
        .DATA_W(DATA_W), .NCH(NCH), .LONG_LOG2(LONG_L2), .SHORT_LOG2(SHORT_L2),
        .THR_FRAC(THR_FRAC), .LEN_W(LEN_W), .RETRIGGER(RETRIG)
    ) dut (
        .clk_clk             (clk),
        .reset_reset_n       (rst_n),
        .in_if               (in_if),
        .out_if              (out_if),
        .cfg_enable          (cfg_enable),
        .cfg_threshold       (cfg_threshold),
        .cfg_passthrough_len (cfg_passthrough_len),
        .cfg_holdoff_len     (cfg_holdoff_len),
        .cfg_det_ch          (cfg_det_ch),
        .cfg_clear_rs        (cfg_clear_rs),
        .dbg_count           (dbg_count),
        .dbg_long_sum        (dbg_long_sum),
        .dbg_short_sum       (dbg_short_sum),
        .det_active          (det_active)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_outv   = 0;
    int n_txn    = 0;

    // Reference model: magnitude history plus burst/holdoff countdowns.
    int            mags[$];
    int            nacc, m_cnt, burst_left, hold_left, pend_mag;
    longint        m_long, m_short;
    bit            exp_valid, pend_v;
    logic [DW-1:0] exp_data, pend_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int i0, input int q0, input int i1, input int q1);
        logic [DW-1:0] d;
        d = '0;
        d[DATA_W +: DATA_W]            = DATA_W'(i0);
        d[0 +: DATA_W]                 = DATA_W'(q0);
        d[3*DATA_W +: DATA_W]          = DATA_W'(i1);
        d[2*DATA_W +: DATA_W]          = DATA_W'(q1);
        return d;
    endfunction

    function automatic int mag_of(input logic [DW-1:0] d, input int ch);
        logic signed [DATA_W-1:0] i_v, q_v;
        int a, b;
        i_v = d[ch*2*DATA_W + DATA_W +: DATA_W];
        q_v = d[ch*2*DATA_W +: DATA_W];
        a = int'(i_v);
        b = int'(q_v);
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        return a + b;
    endfunction

    function automatic int rnd(input int amp);
        return int'($urandom_range(2 * amp, 0)) - amp;
    endfunction

    task automatic model_reset();
        mags.delete();
        nacc = 0; m_cnt = 0; burst_left = 0; hold_left = 0;
        m_long = 0; m_short = 0; pend_v = 0; exp_valid = 0;
    endtask

    task automatic model_sample(input int mag, input logic [DW-1:0] data);
        longint s_long, s_short;
        bit     trig, fwd;
        mags.push_back(mag);
        if (mags.size() > LONG_N) void'(mags.pop_front());
        nacc++;
        s_long = 0;
        s_short = 0;
        foreach (mags[i]) begin
            s_long += mags[i];
            if (i >= mags.size() - SHORT_N) s_short += mags[i];
        end
        m_long = s_long;
        m_short = s_short;
        trig = (nacc >= LONG_N) &&
               (s_short * (LONG_N / SHORT_N) > (s_long * longint'(cfg_threshold)) / (1 << THR_FRAC));
        fwd = 0;
        if (!cfg_enable) fwd = 1;
        else if (hold_left > 0) hold_left--;
        else if (burst_left > 0 || trig) begin
            fwd = 1;
            if (trig && (burst_left == 0 || RETRIG != 0)) begin
                burst_left = (cfg_passthrough_len == 0) ? 1 : int'(cfg_passthrough_len);
                m_cnt++;
            end
            burst_left--;
            if (burst_left == 0) hold_left = int'(cfg_holdoff_len);
        end
        if (fwd) begin
            exp_valid = 1;
            exp_data = data;
        end
        n_txn++;
        $display("txn %0d: mag=%0d long=%0d short=%0d trig=%0d fwd=%0d cnt=%0d",
                 n_txn, mag, s_long, s_short, trig, fwd, m_cnt);
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            exp_data = '0;
            return;
        end
        exp_valid = 0;
        if (cfg_clear_rs) begin
            model_reset();
            return;
        end
        if (!cfg_enable) begin
            burst_left = 0;
            hold_left = 0;
        end
        if (pend_v) model_sample(pend_mag, pend_data);
        pend_v = in_if.valid;
        if (in_if.valid) begin
            pend_mag = mag_of(in_if.data, int'(cfg_det_ch));
            pend_data = in_if.data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_val("out_valid", 64'(out_if.valid), 64'(exp_valid));
        check_val("out_data", 64'(out_if.data), 64'(exp_data));
        check_val("long_sum", 64'(dbg_long_sum), 64'(m_long));
        check_val("short_sum", 64'(dbg_short_sum), 64'(m_short));
        check_val("dbg_count", 64'(dbg_count), 64'(m_cnt));
        check_val("det_active", 64'(det_active), 64'(burst_left > 0));
        if (out_if.valid) n_outv++;
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_if.valid = 1'b1;
        in_if.data = d;
        tick();
        in_if.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_clear();
        cfg_clear_rs = 1'b1;
        tick();
        cfg_clear_rs = 1'b0;
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int amp, seg_len;
        model_reset();
        exp_data = '0;
        in_if.valid = 1'b0;
        in_if.data = '0;

        // Reset held with random inputs: everything stays at zero.
        for (int k = 0; k < 6; k++) begin
            in_if.valid = 1'($urandom_range(1, 0));
            in_if.data = mk(rnd(2000), rnd(2000), rnd(2000), rnd(2000));
            cfg_enable = 1'($urandom_range(1, 0));
            cfg_clear_rs = 1'($urandom_range(1, 0));
            cfg_threshold = 8'($urandom);
            cfg_passthrough_len = 16'($urandom);
            cfg_holdoff_len = 16'($urandom);
            cfg_det_ch = 1'($urandom_range(1, 0));
            tick();
        end
        in_if.valid = 1'b0;
        cfg_enable = 1'b1;
        cfg_clear_rs = 1'b0;
        cfg_threshold = 8'd32;
        cfg_passthrough_len = 16'd4;
        cfg_holdoff_len = 16'd2;
        cfg_det_ch = 1'b0;
        rst_n = 1'b1;
        n_outv = 0;
        idle(5);
        check_val("quiet_after_reset", 64'(n_outv), 64'd0);

        // Bypass: every sample forwarded two cycles later.
        cfg_enable = 1'b0;
        n_outv = 0;
        for (int k = 0; k < 10; k++) begin
            send(mk(rnd(2047), rnd(2047), rnd(2047), rnd(2047)));
            idle($urandom_range(3, 0));
        end
        idle(3);
        check_val("bypass_count", 64'(n_outv), 64'd10);

        // Steady I=100 then step to I=1000.
        cfg_enable = 1'b1;
        cfg_passthrough_len = 16'd5;
        cfg_holdoff_len = 16'd3;
        pulse_clear();
        for (int k = 0; k < 256; k++) send(mk(100, 0, rnd(500), rnd(500)));
        idle(2);
        check_val("steady_long", 64'(dbg_long_sum), 64'd25600);
        check_val("steady_short", 64'(dbg_short_sum), 64'd1600);
        check_val("steady_count", 64'(dbg_count), 64'd0);
        send(mk(1000, 0, 0, 0));
        send(mk(1000, 0, 0, 0));
        idle(2);
        check_val("step2_count", 64'(dbg_count), 64'd0);
        send(mk(1000, 0, 0, 0));
        idle(2);
        check_val("step3_count", 64'(dbg_count), 64'd1);
        check_val("step3_active", 64'(det_active), 64'd1);
        for (int k = 0; k < 3; k++) send(mk(1000, 0, 0, 0));

        // Clear in the middle of a burst, with a same-cycle sample.
        in_if.valid = 1'b1;
        in_if.data = mk(1000, 0, 0, 0);
        cfg_clear_rs = 1'b1;
        tick();
        cfg_clear_rs = 1'b0;
        in_if.valid = 1'b0;
        check_val("clear_outv", 64'(out_if.valid), 64'd0);
        check_val("clear_long", 64'(dbg_long_sum), 64'd0);
        check_val("clear_active", 64'(det_active), 64'd0);
        for (int k = 0; k < 200; k++) send(mk(10, 0, 0, 0));
        for (int k = 0; k < 55; k++) send(mk(2000, 0, 0, 0));
        idle(2);
        check_val("warmup_count", 64'(dbg_count), 64'd0);

        // Full-scale negative components on both I and Q.
        pulse_clear();
        for (int k = 0; k < 16; k++) send(mk(-2048, -2048, 0, 0));
        idle(2);
        check_val("fs_short", 64'(dbg_short_sum), 64'd65536);
        for (int k = 0; k < 240; k++) send(mk(-2048, -2048, 0, 0));
        idle(2);
        check_val("fs_long", 64'(dbg_long_sum), 64'd1048576);

        // Random energy segments with random configuration.
        pulse_clear();
        for (int seg = 0; seg < 40; seg++) begin
            amp = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2047, 400))
                                               : int'($urandom_range(60, 0));
            seg_len = $urandom_range(60, 10);
            if ($urandom_range(2, 0) == 0) begin
                cfg_threshold = 8'($urandom_range(64, 8));
                cfg_passthrough_len = 16'($urandom_range(8, 0));
                cfg_holdoff_len = 16'($urandom_range(5, 0));
                cfg_det_ch = 1'($urandom_range(1, 0));
                cfg_enable = ($urandom_range(9, 0) != 0);
            end
            for (int k = 0; k < seg_len; k++) begin
                if ($urandom_range(3, 0) == 0) idle(1);
                send(mk(rnd(amp), rnd(amp), rnd(amp), rnd(amp)));
                if ($urandom_range(199, 0) == 0) pulse_clear();
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
